// File: rtl/sar_adc_pkg.sv
// Shared types and helpers for the SAR ADC conversion sequencer.
//   sar_state_e : sequencer/core state encoding
//   width_of()  : bits needed to index n items (minimum 1)
//   t_conv()    : cycles for one sample+convert pass
package sar_adc_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSample,
    StConvert,
    StDone
  } sar_state_e;

  function automatic int unsigned width_of(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned t_conv(input int unsigned sample_cyc,
                                         input int unsigned res,
                                         input int unsigned settle_cyc);
    return sample_cyc + res * (settle_cyc + 1);
  endfunction

  localparam int unsigned DefRes        = 8;
  localparam int unsigned DefNch        = 4;
  localparam int unsigned DefSampleCyc  = 2;
  localparam int unsigned DefSettleCyc  = 1;
  localparam int unsigned DefAvgLog2Max = 3;
  localparam int unsigned DefTConv      = t_conv(DefSampleCyc, DefRes, DefSettleCyc);

endpackage

// File: rtl/sar_adc_core.sv
// One SAR conversion: SAMPLE_CYC cycles of sampling, then one bit per
// (SETTLE_CYC+1)-cycle window from MSB to LSB.
//   clk, rst  : clock, async active-high reset
//   go        : start a conversion (taken in idle, or on the final edge of a conversion)
//   cmp_in    : comparator, 1 = Vin >= Vdac
//   sample_en : sample switch (registered)
//   dac_code  : trial code (registered)
//   done      : high during the last cycle of bit 0
//   result    : final code, valid while done is high
module sar_adc_core
  import sar_adc_pkg::*;
#(
  parameter int unsigned RES        = 8,
  parameter int unsigned SAMPLE_CYC = 2,
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           go,
  input  logic           cmp_in,
  output logic           sample_en,
  output logic [RES-1:0] dac_code,
  output logic           done,
  output logic [RES-1:0] result
);

  localparam int unsigned CntMax = (SAMPLE_CYC > SETTLE_CYC + 1) ? SAMPLE_CYC : SETTLE_CYC + 1;
  localparam int unsigned CntW   = width_of(CntMax);
  localparam int unsigned BitW   = width_of(RES);

  sar_state_e      state_q;
  logic [CntW-1:0] cnt_q;
  logic [BitW-1:0] bit_q;
  logic [RES-1:0]  res_q;
  logic [RES-1:0]  dac_q;
  logic            sample_en_q;

  logic            last_slot;
  logic [RES-1:0]  resolved;
  logic [RES-1:0]  next_bit;

  always_comb begin
    last_slot = (state_q == StConvert) && (cnt_q == CntW'(SETTLE_CYC));
    // Keep the trial bit when the comparator says Vin >= Vdac.
    resolved  = cmp_in ? dac_q : res_q;
    next_bit  = RES'(1) << (bit_q - 1'b1);
  end

  // done/result are combinational so the sequencer can publish the result
  // on the same edge that resolves bit 0.
  assign done      = last_slot && (bit_q == '0);
  assign result    = resolved;
  assign sample_en = sample_en_q;
  assign dac_code  = dac_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_q       <= '0;
      res_q       <= '0;
      dac_q       <= '0;
      sample_en_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (go) begin
            state_q     <= StSample;
            sample_en_q <= 1'b1;
            cnt_q       <= '0;
          end
        end
        StSample: begin
          if (cnt_q == CntW'(SAMPLE_CYC - 1)) begin
            state_q     <= StConvert;
            sample_en_q <= 1'b0;
            cnt_q       <= '0;
            bit_q       <= BitW'(RES - 1);
            res_q       <= '0;
            dac_q       <= RES'(1) << (RES - 1);
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StConvert: begin
          if (last_slot) begin
            cnt_q <= '0;
            res_q <= resolved;
            if (bit_q == '0) begin
              dac_q <= '0;
              // Back-to-back restart keeps averaging passes gapless.
              if (go) begin
                state_q     <= StSample;
                sample_en_q <= 1'b1;
              end else begin
                state_q <= StIdle;
              end
            end else begin
              bit_q <= bit_q - 1'b1;
              dac_q <= resolved | next_bit;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: rtl/sar_adc_seq.sv
// SAR conversion sequencer: averaging over 2^avg_log2 conversions, optional
// multi-channel scan, and the registered result interface.
//   clk, rst   : clock, async active-high reset
//   start      : begin a result (idle only); latches ch_sel and avg_log2
//   scan       : sampled at DONE, 1 = continue on the next channel
//   cmp_in     : comparator input
//   mux_sel    : analog mux channel
//   sample_en  : sample switch
//   dac_code   : DAC trial code
//   busy       : high outside IDLE
//   data_valid : one-cycle pulse with data/data_ch
//   data       : averaged result, data_ch its channel
module sar_adc_seq
  import sar_adc_pkg::*;
#(
  parameter int unsigned RES          = 8,
  parameter int unsigned NCH          = 4,
  parameter int unsigned SAMPLE_CYC   = 2,
  parameter int unsigned SETTLE_CYC   = 1,
  parameter int unsigned AVG_LOG2_MAX = 3,
  localparam int unsigned CW          = width_of(NCH),
  localparam int unsigned AW          = width_of(AVG_LOG2_MAX + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [CW-1:0]  ch_sel,
  input  logic [AW-1:0]  avg_log2,
  input  logic           scan,
  input  logic           cmp_in,
  output logic [CW-1:0]  mux_sel,
  output logic           sample_en,
  output logic [RES-1:0] dac_code,
  output logic           busy,
  output logic           data_valid,
  output logic [RES-1:0] data,
  output logic [CW-1:0]  data_ch
);

  localparam int unsigned AccW = RES + AVG_LOG2_MAX;
  localparam int unsigned NW   = AVG_LOG2_MAX + 1;

  sar_state_e      state_q;
  logic [CW-1:0]   ch_q;
  logic [AW-1:0]   avg_q;
  logic [NW-1:0]   conv_cnt_q;
  logic [AccW-1:0] acc_q;
  logic            busy_q;
  logic            data_valid_q;
  logic [RES-1:0]  data_q;
  logic [CW-1:0]   data_ch_q;

  logic            conv_done;
  logic [RES-1:0]  conv_result;
  logic            in_conv;
  logic            more;
  logic            go;
  logic [AW-1:0]   avg_clamped;
  logic [NW-1:0]   n_last;
  logic [AccW-1:0] acc_sum;
  logic [RES-1:0]  data_next;
  logic [CW-1:0]   ch_next;

  always_comb begin
    avg_clamped = (avg_log2 > AW'(AVG_LOG2_MAX)) ? AW'(AVG_LOG2_MAX) : avg_log2;
    n_last      = NW'((32'd1 << avg_q) - 32'd1);
    more        = (conv_cnt_q != n_last);
    in_conv     = (state_q == StSample) || (state_q == StConvert);
    go          = ((state_q == StIdle) && start) ||
                  (in_conv && conv_done && more) ||
                  ((state_q == StDone) && scan);
    acc_sum     = acc_q + AccW'(conv_result);
    data_next   = RES'(acc_sum >> avg_q);
    ch_next     = (ch_q == CW'(NCH - 1)) ? '0 : ch_q + 1'b1;
  end

  sar_adc_core #(
    .RES        (RES),
    .SAMPLE_CYC (SAMPLE_CYC),
    .SETTLE_CYC (SETTLE_CYC)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .go        (go),
    .cmp_in    (cmp_in),
    .sample_en (sample_en),
    .dac_code  (dac_code),
    .done      (conv_done),
    .result    (conv_result)
  );

  assign mux_sel    = ch_q;
  assign busy       = busy_q;
  assign data_valid = data_valid_q;
  assign data       = data_q;
  assign data_ch    = data_ch_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      ch_q         <= '0;
      avg_q        <= '0;
      conv_cnt_q   <= '0;
      acc_q        <= '0;
      busy_q       <= 1'b0;
      data_valid_q <= 1'b0;
      data_q       <= '0;
      data_ch_q    <= '0;
    end else begin
      data_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q    <= StSample;
            ch_q       <= ch_sel;
            avg_q      <= avg_clamped;
            conv_cnt_q <= '0;
            acc_q      <= '0;
            busy_q     <= 1'b1;
          end
        end
        StSample, StConvert: begin
          if (conv_done) begin
            if (more) begin
              acc_q      <= acc_sum;
              conv_cnt_q <= conv_cnt_q + 1'b1;
              state_q    <= StSample;
            end else begin
              acc_q        <= acc_sum;
              conv_cnt_q   <= '0;
              data_q       <= data_next;
              data_ch_q    <= ch_q;
              data_valid_q <= 1'b1;
              state_q      <= StDone;
            end
          end else if ((state_q == StSample) && !sample_en) begin
            state_q <= StConvert;
          end
        end
        StDone: begin
          acc_q <= '0;
          if (scan) begin
            ch_q    <= ch_next;
            state_q <= StSample;
          end else begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_adc_seq.sv
module tb_sar_adc_seq;

  localparam int T_CONV = 2 + 8 * (1 + 1);

  logic       clk = 1'b0;
  logic       rst;
  logic       start, start2, scan;
  logic [1:0] ch_sel, avg_log2;
  logic       cmp_in, cmp_in2;
  logic [1:0] mux_sel, mux_sel2;
  logic       sample_en, sample_en2;
  logic [7:0] dac_code, dac_code2;
  logic       busy, busy2, data_valid, data_valid2;
  logic [7:0] data, data2;
  logic [1:0] data_ch, data_ch2;

  int checks   = 0;
  int failures = 0;

  logic [7:0] vin [4];
  logic [7:0] seq_vin [8];
  logic       use_seq;
  int         seq_base;
  int         seq_idx;
  int         sample_pulses = 0;
  logic       sample_prev = 1'b0;
  logic [7:0] cur_vin;
  logic [7:0] trials [$];
  logic [7:0] last_dac;

  sar_adc_seq dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .ch_sel     (ch_sel),
    .avg_log2   (avg_log2),
    .scan       (scan),
    .cmp_in     (cmp_in),
    .mux_sel    (mux_sel),
    .sample_en  (sample_en),
    .dac_code   (dac_code),
    .busy       (busy),
    .data_valid (data_valid),
    .data       (data),
    .data_ch    (data_ch)
  );

  sar_adc_seq #(.AVG_LOG2_MAX(2)) dut2 (
    .clk        (clk),
    .rst        (rst),
    .start      (start2),
    .ch_sel     (ch_sel),
    .avg_log2   (avg_log2),
    .scan       (1'b0),
    .cmp_in     (cmp_in2),
    .mux_sel    (mux_sel2),
    .sample_en  (sample_en2),
    .dac_code   (dac_code2),
    .busy       (busy2),
    .data_valid (data_valid2),
    .data       (data2),
    .data_ch    (data_ch2)
  );

  always #5 clk = ~clk;

  // Ideal comparator; in sequence mode each conversion sees the next seq_vin entry.
  always_comb begin
    seq_idx = sample_pulses - seq_base - 1;
    if (seq_idx < 0) seq_idx = 0;
    if (seq_idx > 7) seq_idx = 7;
    cur_vin = use_seq ? seq_vin[seq_idx[2:0]] : vin[mux_sel];
  end
  assign cmp_in  = (cur_vin >= dac_code);
  assign cmp_in2 = (vin[mux_sel2] >= dac_code2);

  always @(posedge clk) begin
    sample_prev <= sample_en;
    if (sample_en && !sample_prev) sample_pulses <= sample_pulses + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expd);
    checks++;
    if (got !== expd) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expd);
    end
  endtask

  task automatic do_start(input int c, input int a);
    ch_sel   = 2'(c);
    avg_log2 = 2'(a);
    trials.delete();
    last_dac = 8'h00;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  // Returns edges waited until data_valid is seen, -1 on timeout.
  task automatic wait_valid(input int limit, output int n);
    n = -1;
    for (int k = 1; k <= limit; k++) begin
      @(posedge clk); #1;
      if (dac_code != last_dac && dac_code != 8'h00) trials.push_back(dac_code);
      last_dac = dac_code;
      if (data_valid) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic count_valid(input int cycles, output int cnt);
    cnt = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk); #1;
      if (data_valid) cnt++;
    end
  endtask

  task automatic run_and_check(input string tag, input int c, input int a,
                               input logic [7:0] expd, input int exp_cyc);
    int n;
    do_start(c, a);
    wait_valid(400, n);
    check_eq({tag, "_cycle"}, n + 1, exp_cyc);
    check_eq({tag, "_data"}, data, expd);
    check_eq({tag, "_ch"}, data_ch, c);
    @(posedge clk); #1;
    check_eq({tag, "_idle"}, {busy, data_valid}, 0);
  endtask

  // Binary search trial codes for an ideal comparator.
  task automatic check_trials(input string tag, input logic [7:0] v);
    logic [7:0] code, t;
    code = 8'h00;
    check_eq({tag, "_ntrials"}, trials.size(), 8);
    for (int i = 7; i >= 0; i--) begin
      t = code | (8'd1 << i);
      if (trials.size() > 7 - i) check_eq({tag, "_trial"}, trials[7 - i], t);
      if (v >= t) code = t;
    end
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_mux"}, mux_sel, 0);
    check_eq({tag, "_smp"}, sample_en, 0);
    check_eq({tag, "_dac"}, dac_code, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_dv"}, data_valid, 0);
    check_eq({tag, "_data"}, data, 0);
    check_eq({tag, "_dch"}, data_ch, 0);
  endtask

  initial begin
    int n, cnt, sum, a, c, pulses0;
    logic [7:0] expd;
    rst = 1'b1; start = 1'b0; start2 = 1'b0; scan = 1'b0;
    ch_sel = '0; avg_log2 = '0; use_seq = 1'b0; seq_base = 0; last_dac = '0;
    for (int i = 0; i < 4; i++) vin[i] = 8'h00;
    for (int i = 0; i < 8; i++) seq_vin[i] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Single conversion with trial sequence.
    vin[2] = 8'h5A;
    do_start(2, 0);
    check_eq("t1_busy", busy, 1);
    check_eq("t1_mux", mux_sel, 2);
    check_eq("t1_smp", sample_en, 1);
    wait_valid(100, n);
    check_eq("t1_cycle", n + 1, T_CONV + 1);
    check_eq("t1_data", data, 8'h5A);
    check_eq("t1_ch", data_ch, 2);
    check_trials("t1", 8'h5A);
    @(posedge clk); #1;
    check_eq("t1_busy_drop", busy, 0);
    check_eq("t1_hold", data, 8'h5A);

    // Extremes.
    vin[1] = 8'h00;
    do_start(1, 0);
    wait_valid(100, n);
    check_eq("t2_zero", data, 8'h00);
    check_trials("t2z", 8'h00);
    @(posedge clk); #1;
    vin[1] = 8'hFF;
    do_start(1, 0);
    wait_valid(100, n);
    check_eq("t2_full", data, 8'hFF);
    check_trials("t2f", 8'hFF);
    @(posedge clk); #1;

    // Averaging with a per-conversion input sequence.
    use_seq = 1'b1;
    seq_base = sample_pulses;
    pulses0 = sample_pulses;
    seq_vin[0] = 8'h10; seq_vin[1] = 8'h11; seq_vin[2] = 8'h12; seq_vin[3] = 8'h13;
    run_and_check("t3", 0, 2, 8'h11, 4 * T_CONV + 1);
    check_eq("t3_pulses", sample_pulses - pulses0, 4);

    // Randomised averaging.
    for (int r = 0; r < 8; r++) begin
      c = int'($urandom_range(0, 3));
      a = int'($urandom_range(0, 3));
      seq_base = sample_pulses;
      sum = 0;
      for (int i = 0; i < 8; i++) seq_vin[i] = 8'($urandom_range(0, 255));
      for (int i = 0; i < (1 << a); i++) sum += seq_vin[i];
      expd = 8'(sum >> a);
      run_and_check("rnd", c, a, expd, (1 << a) * T_CONV + 1);
    end
    use_seq = 1'b0;

    // Scan across channels, then drop scan during the fourth result.
    for (int i = 0; i < 4; i++) vin[i] = 8'(32 * i + 1);
    scan = 1'b1;
    do_start(3, 0);
    wait_valid(100, n);
    check_eq("t4_first_cycle", n + 1, T_CONV + 1);
    check_eq("t4_data0", data, 8'h61);
    check_eq("t4_ch0", data_ch, 3);
    for (int j = 1; j < 3; j++) begin
      wait_valid(100, n);
      check_eq("t4_spacing", n, T_CONV + 1);
      check_eq("t4_data", data, vin[(3 + j) % 4]);
      check_eq("t4_ch", data_ch, (3 + j) % 4);
    end
    @(posedge clk); #1;
    scan = 1'b0;
    check_eq("t4_busy_mid", busy, 1);
    wait_valid(100, n);
    check_eq("t4_last_spacing", n + 1, T_CONV + 1);
    check_eq("t4_data3", data, 8'h41);
    check_eq("t4_ch3", data_ch, 2);
    @(posedge clk); #1;
    check_eq("t4_busy_drop", busy, 0);

    // Start while busy is ignored.
    vin[1] = 8'($urandom_range(1, 255));
    do_start(1, 0);
    repeat (4) @(posedge clk);
    #1;
    ch_sel = 2'd0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_valid(100, n);
    check_eq("t5_cycle", n, T_CONV - 5);
    check_eq("t5_data", data, vin[1]);
    check_eq("t5_ch", data_ch, 1);
    count_valid(40, cnt);
    check_eq("t5_single", cnt, 0);
    check_eq("t5_idle", busy, 0);

    // Reset mid-conversion.
    do_start(2, 0);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_zero("t5_rst");
    count_valid(3, cnt);
    rst = 1'b0;
    begin
      int cnt2;
      count_valid(30, cnt2);
      check_eq("t5_no_valid", cnt + cnt2, 0);
    end
    vin[2] = 8'($urandom_range(0, 255));
    run_and_check("t5_after", 2, 0, vin[2], T_CONV + 1);

    // Clamped averaging exponent on the AVG_LOG2_MAX=2 instance.
    vin[1] = 8'($urandom_range(0, 255));
    ch_sel = 2'd1;
    avg_log2 = 2'd3;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    n = -1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (data_valid2) begin
        n = k;
        break;
      end
    end
    check_eq("t6_cycle", n + 1, 4 * T_CONV + 1);
    check_eq("t6_data", data2, vin[1]);
    check_eq("t6_ch", data_ch2, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
